bayer_mosaic_src: RTL
=====================

// Module: bayer_mosaic_src
// PURPOSE
//  Re-mosaics a full-RGB pixel stream into the single-channel Bayer RAW stream consumed by processing.
//  Bayer pattern: even rows G B G B..., odd rows R G R G...
//  Inserts fixed inter-row blanking, then flushes the pipeline at frame end.
//  Sits upstream of processing (iValid/iData); hardware counterpart of the bench stimulus path.
// PARAMETERS
//  width        320  active pixels per row
//  height       240  rows per frame
//  blankCycles  16   oValid=0 cycles inserted after every row, including the last; must be >=1
//  fifoDepth    32   input FIFO entries; power of 2, >= blankCycles
// PORTS
//  clk              in   1  single clock
//  reset            in   1  synchronous, active-high
//  iValid           in   1  RGB pixel present
//  iReady           out  1  FIFO can accept; transfer = iValid & iReady
//  iR, iG, iB       in   8  RGB pixel, raster order
//  iDownstreamDone  in   1  downstream frame complete (e.g. oDoneDemosaic)
//  oValid           out  1  Bayer sample valid (feeds processing iValid)
//  oData            out  8  Bayer sample (feeds processing iData)
//  oRowEnd          out  1  high with the last sample of each row
//  oFrameDone       out  1  one-cycle pulse when frame + flush complete
// BEHAVIOUR
//  Reset: oValid=0, oData=0, oRowEnd=0, oFrameDone=0, iReady=0.
//   FIFO emptied; row=col=0; state=ACTIVE; iReady=1 from first cycle after reset.
//  FIFO:
//   - 24-bit {R,G,B} entries; iReady = !full.
//   - No push-through-pop when full.
//   - Pushes are accepted in every state; pixels arriving during BLANK/FLUSH/DONE are kept for the next frame.
//  States (registered FSM):
//   ACTIVE:
//    - FIFO non-empty: pop one entry; next cycle oValid=1, oData=sel(row,col); col++.
//    - FIFO empty: oValid=0, counters hold (bubble, no blank inserted).
//    - At col==width-1: oRowEnd=1 on that sample; col<=0; blank counter<=blankCycles; ->BLANK.
//   BLANK:
//    - oValid=0, oData=0; counter decrements.
//    - At 1: if row==height-1 -> FLUSH, else row++ and ->ACTIVE.
//   FLUSH:
//    - oValid=1, oData=0 every cycle; no pops.
//    - On iDownstreamDone=1: oValid=0 that cycle, ->DONE.
//   DONE (1 cycle):
//    - oFrameDone=1, row<=0, col<=0, ->ACTIVE.
//  sel(row,col):
//   - row[0]=0: col[0]=0 -> G, else B.
//   - row[0]=1: col[0]=0 -> R, else G.
//  Latency: pop to oValid is exactly 1 cycle; all outputs registered.
//  iDownstreamDone is ignored outside FLUSH.
//  Reset mid-frame: discards FIFO contents and the partial frame; next sample output is row 0 col 0 (G).
//  Counters: col is $clog2(width) bits, row is $clog2(height) bits; no wrap other than the explicit resets above.
// TESTING
//  T1 Pattern:
//   - width=4, height=2; push R=10+i, G=50+i, B=90+i for i=0..7, iValid held.
//   - oData = 50, 91, 52, 93 | blank | 14, 55, 16, 57 | blank.
//  T2 Blanking:
//   - Continuous input, blankCycles=16.
//   - Exactly 16 oValid=0 cycles after every oRowEnd; oRowEnd once per row.
//  T3 Bubbles:
//   - iValid toggled 1/0 every cycle.
//   - oValid gaps are bubbles only; sequence and column count unchanged vs T1; no early blanking.
//  T4 Backpressure:
//   - fifoDepth=32, continuous iValid across blanking.
//   - iReady drops when 32 entries held; no pixel lost or duplicated over a 320x240 frame.
//  T5 Flush:
//   - After last blank, oValid=1, oData=0 until iDownstreamDone pulsed at cycle +40.
//   - Next cycle oValid=0; following cycle oFrameDone=1 for 1 cycle.
//   - Next frame starts at row 0 (G).
//  T6 Reset:
//   - Assert reset mid row 5 for 2 cycles.
//   - All outputs 0 during reset; first post-reset sample is the G of the next pushed pixel.

Source files
------------

// File: rtl/bayer_mosaic_src.sv
// bayer_mosaic_src: re-mosaics an RGB pixel stream into a GBRG Bayer RAW stream with row blanking and frame flush
module bayer_mosaic_src #(
    parameter int width = 320,
    parameter int height = 240,
    parameter int blankCycles = 16,
    parameter int fifoDepth = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iValid,
    output logic       iReady,
    input  logic [7:0] iR,
    input  logic [7:0] iG,
    input  logic [7:0] iB,
    input  logic       iDownstreamDone,
    output logic       oValid,
    output logic [7:0] oData,
    output logic       oRowEnd,
    output logic       oFrameDone
);
    localparam int aw = $clog2(fifoDepth);
    localparam int cw = $clog2(width);
    localparam int rw = $clog2(height);
    localparam int bw = $clog2(blankCycles + 1);
    typedef enum logic [1:0] {ACTIVE, BLANK, FLUSH, DONE} state_t;
    state_t state, state_n;
    logic [23:0] mem [fifoDepth];
    logic [aw-1:0] wp, rp;
    logic [aw:0] cnt;
    logic [cw-1:0] col;
    logic [rw-1:0] row;
    logic [bw-1:0] bcnt;
    logic push, pop, last_col, last_row, row_step;
    logic [23:0] head;
    logic [7:0] sample, data_n;
    logic valid_n, row_end_n, done_n;
    assign iReady = !reset && cnt != (aw + 1)'(fifoDepth);
    assign push = iValid && iReady;
    assign pop = state == ACTIVE && cnt != '0;
    assign head = mem[rp];
    assign last_col = col == cw'(width - 1);
    assign last_row = row == rw'(height - 1);
    assign row_step = state == BLANK && bcnt == bw'(1);
    assign sample = row[0] ? (col[0] ? head[15:8] : head[23:16]) : (col[0] ? head[7:0] : head[15:8]);
    // fifo storage; pushes are accepted in every state
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {iR, iG, iB};
    end
    // fifo pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            wp <= wp + aw'(push);
            rp <= rp + aw'(pop);
            cnt <= cnt + (aw + 1)'(push) - (aw + 1)'(pop);
        end
    end
    // state register
    always_ff @(posedge clk) begin
        state <= reset ? ACTIVE : state_n;
    end
    // next-state: row end starts blanking, last blank of the frame starts the flush
    always_comb begin
        state_n = state;
        case (state)
            ACTIVE: state_n = (pop && last_col) ? BLANK : ACTIVE;
            BLANK: state_n = row_step ? (last_row ? FLUSH : ACTIVE) : BLANK;
            FLUSH: state_n = iDownstreamDone ? DONE : FLUSH;
            DONE: state_n = ACTIVE;
        endcase
    end
    // next output values, registered below so every output is a flop
    always_comb begin
        valid_n = pop || (state == FLUSH && !iDownstreamDone);
        data_n = pop ? sample : 8'd0;
        row_end_n = pop && last_col;
        done_n = state == DONE;
    end
    // output registers and raster counters
    always_ff @(posedge clk) begin
        if (reset) begin
            oValid <= 1'b0;
            oData <= 8'd0;
            oRowEnd <= 1'b0;
            oFrameDone <= 1'b0;
            col <= '0;
            row <= '0;
            bcnt <= '0;
        end else begin
            oValid <= valid_n;
            oData <= data_n;
            oRowEnd <= row_end_n;
            oFrameDone <= done_n;
            col <= (state == DONE || (pop && last_col)) ? '0 : col + cw'(pop);
            row <= state == DONE ? '0 : row + rw'(row_step && !last_row);
            bcnt <= (pop && last_col) ? bw'(blankCycles) : bcnt - bw'(state == BLANK);
        end
    end
endmodule
